trunk_arbiter: RTL and testbench
================================

// Module: trunk_arbiter
// PURPOSE
//  Shares one outgoing trunk among N_LINES telephone line controllers. Grants the trunk
//  round-robin to a requesting line, then times its dial and call phases with an
//  internal tick prescaler. Raises timeout to the owner line. Sits between the
//  per-line FSMs and the trunk interface.
// PARAMETERS
//  N_LINES     4     number of requesting lines (>=2)
//  TICK_DIV    1000  pclk cycles per timer tick (>=1)
//  DIAL_TICKS  5     ticks allowed in dial phase before timeout (>=1)
//  CALL_TICKS  250   ticks allowed in connected phase before timeout (>=1)
// PORTS
//  pclk        in   1                  clock
//  presetn     in   1                  asynchronous active-low reset
//  req         in   N_LINES            level; line i wants/holds trunk (drop = cancel/hang-up)
//  rel         in   N_LINES            1-cycle pulse; line i ends call
//  connect     in   1                  trunk reports far end picked up
//  grant       out  N_LINES            one-hot owner; all zero when trunk free
//  grant_id    out  $clog2(N_LINES)    index of owner; 0 when free
//  busy        out  1                  trunk owned (GRANT/CONNECTED/TIMEOUT)
//  dialing     out  1                  state==GRANT
//  in_call     out  1                  state==CONNECTED
//  timeout     out  1                  state==TIMEOUT
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, rr_ptr=0, prescaler=0, tick_cnt=0.
//    Reset mid-call drops the grant immediately; no RELEASE cycle occurs.
//  - All outputs are registered and decoded from state/owner only.
//  - States: IDLE, GRANT, CONNECTED, TIMEOUT, RELEASE.
//  - IDLE: if |req, the owner is the first set req[i] searching i = rr_ptr, rr_ptr+1, ...
//    with wrap mod N_LINES. Go to GRANT; grant is asserted the cycle after req is seen.
//  - GRANT (priority order):
//    1. ~req[owner] -> RELEASE.
//    2. connect -> CONNECTED.
//    3. tick_cnt==DIAL_TICKS -> TIMEOUT.
//  - CONNECTED (priority order):
//    1. rel[owner] | ~req[owner] -> RELEASE.
//    2. tick_cnt==CALL_TICKS -> TIMEOUT.
//  - TIMEOUT: grant held, timeout=1. ~req[owner] -> RELEASE; rel is ignored here.
//  - RELEASE: one cycle with grant=0 and busy=0. rr_ptr <= (owner+1) mod N_LINES,
//    then IDLE. The next grant therefore comes at least 2 cycles after release.
//  - rel and connect are ignored in all other states. rel from non-owner lines is always ignored.
//  - Timer:
//    - Prescaler counts 0..TICK_DIV-1 and pulses tick on TICK_DIV-1.
//    - tick_cnt (width $clog2(CALL_TICKS+1)) increments on tick and saturates.
//    - Both counters clear on every entry to GRANT and to CONNECTED, and hold at 0
//      in IDLE, TIMEOUT and RELEASE.
//    - Timeout latency: timeout rises exactly DIAL_TICKS*TICK_DIV+1 cycles after grant
//      rises (dial phase). It rises CALL_TICKS*TICK_DIV+1 cycles after in_call rises
//      (call phase).
//  - Simultaneous events: the priority order above decides; a timeout is suppressed
//    by a same-cycle release or drop.
//  - A req change on a non-owner line while busy has no effect until IDLE.
//  - An owner req that stays high after RELEASE is re-arbitrated normally behind the
//    other lines (fairness).
// TESTING (TICK_DIV=4, DIAL_TICKS=5, CALL_TICKS=250, N_LINES=4)
//  1. Reset: presetn low mid-CONNECTED -> all outputs 0 on the same edge. After release,
//     req=4'b0001 -> grant=0001 one cycle later.
//  2. Round-robin: req=1111 held; each grant is ended by a req drop and reassert.
//     -> grant sequence 0001,0010,0100,1000,0001.
//  3. Dial timeout: req[2]=1, no connect -> timeout=1 exactly 21 cycles after grant=0100.
//     Then drop req[2] -> RELEASE, then IDLE.
//  4. Call: connect 3 cycles after grant -> in_call=1. rel[owner] at cycle 100 -> RELEASE.
//     rel from a non-owner earlier -> no effect.
//  5. Call timeout: connect, no rel -> timeout 1001 cycles after in_call. A rel while in
//     TIMEOUT is ignored.
//  6. Collision: connect and ~req[owner] in the same GRANT cycle -> RELEASE.
//     tick_cnt==DIAL_TICKS in the same cycle as connect -> CONNECTED.

Source files
------------

// File: rtl/trunk_arbiter.sv
// Round-robin owner of one outgoing trunk shared by N_LINES line controllers.
// Times the dial and call phases with a tick prescaler and flags timeout to the owner.
module trunk_arbiter #(
  parameter int unsigned N_LINES    = 4,
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned DIAL_TICKS = 5,
  parameter int unsigned CALL_TICKS = 250
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic [N_LINES-1:0]         req,
  input  logic [N_LINES-1:0]         rel,
  input  logic                       connect,
  output logic [N_LINES-1:0]         grant,
  output logic [$clog2(N_LINES)-1:0] grant_id,
  output logic                       busy,
  output logic                       dialing,
  output logic                       in_call,
  output logic                       timeout
);

  localparam int unsigned IW = $clog2(N_LINES);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW = $clog2(CALL_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_CONNECTED,
    S_TIMEOUT,
    S_RELEASE
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;

  logic [N_LINES-1:0]   grant_q, grant_d;
  logic [IW-1:0]        grant_id_q, grant_id_d;
  logic                 busy_q, busy_d;
  logic                 dialing_q, dialing_d;
  logic                 in_call_q, in_call_d;
  logic                 timeout_q, timeout_d;

  logic                 arb_hit;
  logic [IW-1:0]        arb_idx;
  logic [IW-1:0]        cand;
  logic                 owner_req;
  logic                 owner_rel;
  logic                 tick;

  assign owner_req = req[owner_q];
  assign owner_rel = rel[owner_q];
  assign tick      = (presc_q == PW'(TICK_DIV - 1));

  // First requesting line at or after rr_ptr, wrapping modulo N_LINES.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      cand = IW'((32'(rr_ptr_q) + i) % N_LINES);
      if (!arb_hit && req[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  // Next state, phase timer and output decode.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    presc_d    = '0;
    tick_cnt_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          state_d = S_GRANT;
          owner_d = arb_idx;
        end
      end
      S_GRANT: begin
        if (!owner_req)                              state_d = S_RELEASE;
        else if (connect)                            state_d = S_CONNECTED;
        else if (tick_cnt_q == TW'(DIAL_TICKS))      state_d = S_TIMEOUT;
      end
      S_CONNECTED: begin
        if (owner_rel || !owner_req)                 state_d = S_RELEASE;
        else if (tick_cnt_q == TW'(CALL_TICKS))      state_d = S_TIMEOUT;
      end
      S_TIMEOUT: begin
        if (!owner_req)                              state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d  = S_IDLE;
        rr_ptr_d = (owner_q == IW'(N_LINES - 1)) ? '0 : owner_q + IW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Counters run only while staying in a timed phase; any entry restarts them.
    if ((state_d == state_q) && ((state_q == S_GRANT) || (state_q == S_CONNECTED))) begin
      presc_d    = tick ? '0 : presc_q + PW'(1);
      tick_cnt_d = (tick && (tick_cnt_q != '1)) ? tick_cnt_q + TW'(1) : tick_cnt_q;
    end

    busy_d     = (state_d == S_GRANT) || (state_d == S_CONNECTED) || (state_d == S_TIMEOUT);
    grant_d    = busy_d ? (N_LINES'(1) << owner_d) : '0;
    grant_id_d = busy_d ? owner_d : '0;
    dialing_d  = (state_d == S_GRANT);
    in_call_d  = (state_d == S_CONNECTED);
    timeout_d  = (state_d == S_TIMEOUT);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      dialing_q  <= 1'b0;
      in_call_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      dialing_q  <= dialing_d;
      in_call_q  <= in_call_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign dialing  = dialing_q;
  assign in_call  = in_call_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_trunk_arbiter.sv
// Directed bench for trunk_arbiter: arbitration order, dial/call timers, release and reset.
// Observed vector is {grant[3:0], grant_id[1:0], busy, dialing, in_call, timeout}.
module tb_trunk_arbiter;

  logic       pclk;
  logic       presetn;
  logic [3:0] req;
  logic [3:0] rel;
  logic       connect;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy, dialing, in_call, timeout;

  int checks;
  int errors;
  logic [8:0] exp_v;
  logic [8:0] ov;

  assign ov = {grant, grant_id, busy, dialing, in_call, timeout};

  trunk_arbiter #(
    .N_LINES   (4),
    .TICK_DIV  (4),
    .DIAL_TICKS(5),
    .CALL_TICKS(250)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .req     (req),
    .rel     (rel),
    .connect (connect),
    .grant   (grant),
    .grant_id(grant_id),
    .busy    (busy),
    .dialing (dialing),
    .in_call (in_call),
    .timeout (timeout)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic test_reset;
    presetn = 1'b0; req = '0; rel = '0; connect = 1'b0;
    cyc(2);
    exp_v = 9'b0;
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL reset_idle: got %b want %b", ov, exp_v); end
    presetn = 1'b1;
    req = 4'b0001;
    cyc(1);
    exp_v = {4'b0001, 2'd0, 4'b1100};
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL reset_first_grant: got %b want %b", ov, exp_v); end
    connect = 1'b1;
    cyc(1);
    connect = 1'b0;
    exp_v = {4'b0001, 2'd0, 4'b1010};
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL reset_connected: got %b want %b", ov, exp_v); end
    presetn = 1'b0;
    #1;
    exp_v = 9'b0;
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL reset_midcall_async: got %b want %b", ov, exp_v); end
    cyc(1);
    presetn = 1'b1;
    cyc(1);
    exp_v = {4'b0001, 2'd0, 4'b1100};
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL reset_regrant: got %b want %b", ov, exp_v); end
    req = '0;
    cyc(2);
  endtask

  task automatic test_round_robin;
    presetn = 1'b0;
    cyc(1);
    presetn = 1'b1;
    req = 4'hF;
    cyc(1);
    for (int k = 0; k < 5; k++) begin
      exp_v = {4'(1 << (k % 4)), 2'(k % 4), 4'b1100};
      checks++; if (ov !== exp_v) begin errors++; $display("FAIL rr_grant_%0d: got %b want %b", k, ov, exp_v); end
      if (k < 4) begin
        req = 4'hF & ~4'(1 << k);
        cyc(1);
        exp_v = 9'b0;
        checks++; if (ov !== exp_v) begin errors++; $display("FAIL rr_release_%0d: got %b want %b", k, ov, exp_v); end
        req = 4'hF;
        cyc(2);
      end
    end
    req = '0;
    cyc(2);
  endtask

  task automatic test_dial_timeout;
    req = 4'b0100;
    cyc(1);
    exp_v = {4'b0100, 2'd2, 4'b1100};
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL dial_grant: got %b want %b", ov, exp_v); end
    cyc(20);
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL dial_before_timeout: got %b want %b", ov, exp_v); end
    cyc(1);
    exp_v = {4'b0100, 2'd2, 4'b1001};
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL dial_timeout: got %b want %b", ov, exp_v); end
    req = '0;
    cyc(1);
    exp_v = 9'b0;
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL dial_release: got %b want %b", ov, exp_v); end
    cyc(1);
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL dial_idle: got %b want %b", ov, exp_v); end
  endtask

  task automatic test_call;
    req = 4'b0001;
    cyc(1);
    exp_v = {4'b0001, 2'd0, 4'b1100};
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL call_grant: got %b want %b", ov, exp_v); end
    cyc(2);
    connect = 1'b1;
    cyc(1);
    connect = 1'b0;
    exp_v = {4'b0001, 2'd0, 4'b1010};
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL call_connected: got %b want %b", ov, exp_v); end
    rel = 4'b0010;
    req = 4'b0101;
    cyc(1);
    rel = '0;
    cyc(1);
    req = 4'b0001;
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL call_nonowner_ignored: got %b want %b", ov, exp_v); end
    cyc(90);
    rel = 4'b0001;
    cyc(1);
    rel = '0;
    exp_v = 9'b0;
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL call_rel_release: got %b want %b", ov, exp_v); end
    cyc(1);
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL call_idle_gap: got %b want %b", ov, exp_v); end
    cyc(1);
    exp_v = {4'b0001, 2'd0, 4'b1100};
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL call_rearb: got %b want %b", ov, exp_v); end
    req = '0;
    cyc(2);
  endtask

  task automatic test_call_timeout;
    req = 4'b1000;
    cyc(1);
    exp_v = {4'b1000, 2'd3, 4'b1100};
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL ctmo_grant: got %b want %b", ov, exp_v); end
    connect = 1'b1;
    cyc(1);
    connect = 1'b0;
    cyc(1000);
    exp_v = {4'b1000, 2'd3, 4'b1010};
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL ctmo_before: got %b want %b", ov, exp_v); end
    cyc(1);
    exp_v = {4'b1000, 2'd3, 4'b1001};
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL ctmo_timeout: got %b want %b", ov, exp_v); end
    rel = 4'b1000;
    cyc(1);
    rel = '0;
    cyc(1);
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL ctmo_rel_ignored: got %b want %b", ov, exp_v); end
    req = '0;
    cyc(1);
    exp_v = 9'b0;
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL ctmo_release: got %b want %b", ov, exp_v); end
    cyc(1);
  endtask

  task automatic test_collision;
    req = 4'b0010;
    cyc(1);
    exp_v = {4'b0010, 2'd1, 4'b1100};
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL coll_grant: got %b want %b", ov, exp_v); end
    connect = 1'b1;
    req = '0;
    cyc(1);
    connect = 1'b0;
    exp_v = 9'b0;
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL coll_drop_wins: got %b want %b", ov, exp_v); end
    cyc(1);
    req = 4'b0010;
    cyc(1);
    exp_v = {4'b0010, 2'd1, 4'b1100};
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL coll_regrant: got %b want %b", ov, exp_v); end
    cyc(20);
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL coll_at_limit: got %b want %b", ov, exp_v); end
    connect = 1'b1;
    cyc(1);
    connect = 1'b0;
    exp_v = {4'b0010, 2'd1, 4'b1010};
    checks++; if (ov !== exp_v) begin errors++; $display("FAIL coll_connect_wins: got %b want %b", ov, exp_v); end
    req = '0;
    cyc(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_round_robin();
    test_dial_timeout();
    test_call();
    test_call_timeout();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
